// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with per-register busy scoreboard and registered reads.
// Define REGFILE_MP_BYPASS_EN to let reads see same-cycle writes and claims.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NREAD-1:0]       ren,
    input  logic [NREAD*AW-1:0]    raddr,
    output logic [NREAD*XLEN-1:0]  rdata,
    output logic [NREAD-1:0]       rbusy,
    input  logic [NWRITE-1:0]      wen,
    input  logic [NWRITE*AW-1:0]   waddr,
    input  logic [NWRITE*XLEN-1:0] wdata,
    input  logic                   claim_en,
    input  logic [AW-1:0]          claim_addr
);
    logic [XLEN-1:0]       mem      [NREGS];
    logic [XLEN-1:0]       mem_nxt  [NREGS];
    logic [XLEN-1:0]       src_mem  [NREGS];
    logic [NREGS-1:0]      busy, busy_nxt, src_busy;
    logic [NREAD*XLEN-1:0] rdata_nxt;
    logic [NREAD-1:0]      rbusy_nxt;

    function automatic logic valid(input logic [AW-1:0] a);
        return (a != '0) && (32'(a) < NREGS);
    endfunction

    // ascending port order lets the higher-index port win; the claim is applied last so it beats a retiring write
    always_comb begin
        mem_nxt  = mem;
        busy_nxt = busy;
        for (int p = 0; p < NWRITE; p++) begin
            if (wen[p] && valid(waddr[p*AW +: AW])) begin
                mem_nxt[waddr[p*AW +: AW]]  = wdata[p*XLEN +: XLEN];
                busy_nxt[waddr[p*AW +: AW]] = 1'b0;
            end
        end
        if (claim_en && valid(claim_addr))
            busy_nxt[claim_addr] = 1'b1;
    end

    always_comb begin
`ifdef REGFILE_MP_BYPASS_EN
        src_mem  = mem_nxt;
        src_busy = busy_nxt;
`else
        src_mem  = mem;
        src_busy = busy;
`endif
    end

    always_comb begin
        rdata_nxt = rdata;
        rbusy_nxt = rbusy;
        for (int i = 0; i < NREAD; i++) begin
            if (ren[i]) begin
                rdata_nxt[i*XLEN +: XLEN] = valid(raddr[i*AW +: AW]) ? src_mem[raddr[i*AW +: AW]] : '0;
                rbusy_nxt[i] = valid(raddr[i*AW +: AW]) ? src_busy[raddr[i*AW +: AW]] : 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem   <= '{default: '0};
            busy  <= '0;
            rdata <= '0;
            rbusy <= '0;
        end else begin
            mem   <= mem_nxt;
            busy  <= busy_nxt;
            rdata <= rdata_nxt;
            rbusy <= rbusy_nxt;
        end
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard. It serves as the next-generation architectural register store for the core: configurable data width, register count and number of read/write ports. Reads are registered, and same-cycle write-to-read forwarding can be compiled in or out. Register 0 is hardwired to zero. The array and scoreboard clear on reset.

## Interface
Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (2..64); AW = $clog2(NREGS).
- NREAD, 2, number of read ports (1..4).
- NWRITE, 2, number of write ports (1..2); higher index has priority.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ren  in  NREAD  per-port read enable.
- raddr  in  NREAD*AW  read addresses, port i in bits [i*AW +: AW].
- rdata  out  NREAD*XLEN  registered read data, port i in [i*XLEN +: XLEN].
- rbusy  out  NREAD  registered busy flag of the register read by port i.
- wen  in  NWRITE  per-port write enable.
- waddr  in  NWRITE*AW  write addresses.
- wdata  in  NWRITE*XLEN  write data.
- claim_en  in  1  mark claim_addr busy (producer issued).
- claim_addr  in  AW  register to mark busy.

## Operation
- Storage: NREGS x XLEN array plus a NREGS-bit busy vector.
- Write, per cycle:
  - Each port with wen=1 writes wdata to waddr.
  - Writes to address 0 or address >= NREGS are dropped.
  - Two ports writing the same address in one cycle: the higher-index port's data is stored.
- Busy update, per cycle:
  - Any accepted write to address A clears busy[A].
  - claim_en sets busy[claim_addr].
  - Claim and write to the same address in the same cycle: claim wins, so busy stays set (new producer supersedes the retiring one).
  - Claims to address 0 or address >= NREGS are ignored; busy[0] is always 0.
- Read, per port i:
  - If ren[i]=1, rdata_i and rbusy_i are loaded at the clock edge.
  - If ren[i]=0, rdata_i and rbusy_i hold their previous values.
  - Address 0 or address >= NREGS returns data 0 and busy 0.
- Forwarding (see Configuration):
  - Governs whether a read sees same-cycle writes and claims.
  - rdata and rbusy always come from the same snapshot (both pre-update or both post-update).
- Reset (resetn low, asynchronous): all registers, the busy vector, rdata and rbusy go to 0 immediately and remain 0 while resetn is low. Reset asserted mid-operation discards any in-flight write or claim that cycle.

## Timing
- Read latency: exactly 1 cycle. raddr and ren are sampled at edge N; rdata and rbusy are valid after edge N and stable until the next enabled read.
- Write latency: data is stored at edge N. A read issued at edge N+1 or later always returns it, with or without forwarding.
- Busy visibility: a claim at edge N is seen by reads at edge N+1 in all configurations, and at edge N itself when forwarding is on.
- No stalls or back-pressure: every port accepts every cycle, with unlimited throughput.
- After deassertion of resetn, the first edge can perform reads, writes and claims.
- All outputs reset to 0: rdata = 0, rbusy = 0.

## Configuration
- REGFILE_MP_BYPASS_EN defined:
  - A read at edge N to address A returns the highest-priority same-cycle wdata for A.
  - rbusy returns busy[A] after this cycle's claim/clear resolution.
- Not defined:
  - Reads return the array contents and busy bit as they were before edge N.
  - Same-cycle writes and claims are invisible until edge N+1.
  - No forwarding muxes are built.

## Test plan
- Reset/zero:
  - Stimulus: hold resetn low mid-run, release, then read addresses 0..31 on both ports.
  - Response: every rdata = 0 and rbusy = 0; rdata drops to 0 asynchronously while resetn is low.
- x0 hardwire:
  - Stimulus: write 32'hDEADBEEF to address 0, claim address 0, then read address 0.
  - Response: rdata = 0, rbusy = 0.
- Write priority:
  - Stimulus: port0 writes 32'h1111 and port1 writes 32'h2222 to address 5 at the same edge; read address 5 the next cycle.
  - Response: rdata = 32'h2222.
- Forwarding:
  - Stimulus: write 32'hA5A5A5A5 to address 7 and read address 7 at the same edge.
  - Response: rdata = 32'hA5A5A5A5 with REGFILE_MP_BYPASS_EN; the old value (0 after reset) without it.
- Scoreboard:
  - Stimulus: claim address 3 at edge N, read address 3 at N+1, write address 3 at N+2, read again at N+3.
  - Response: rbusy = 1 at the first read, 0 at the second.
  - Also: claim and write address 3 at the same edge leaves busy[3] = 1.
- Read hold:
  - Stimulus: read address 9 (value 32'h99) with ren=1, then ren=0 while address 9 is rewritten to 32'h77.
  - Response: rdata stays 32'h99 until ren returns to 1, then reads 32'h77.
